// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Sits beside the ALU in EX. The pipeline stalls while busy is high and
// captures result on the cycle that done pulses.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   start     in   1      request, accepted only in IDLE or DONE
//   div_op    in   2      0=DIV 1=DIVU 2=REM 3=REMU, sampled on accept
//   dividend  in   WIDTH  rs1, sampled on accept
//   divisor   in   WIDTH  rs2, sampled on accept
//   busy      out  1      high in CALC and FIX
//   done      out  1      one-cycle pulse, result valid
//   result    out  WIDTH  quotient or remainder, held until the next op's FIX
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// CALC   | one quotient bit per clock, WIDTH clocks
// FIX    | sign fixup, result register loaded
// DONE   | done pulse; a new start is accepted here back-to-back
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;

  logic             w_accept;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_signed   = ~div_op[0];
  assign w_a_neg    = w_signed & dividend[WIDTH-1];
  assign w_b_neg    = w_signed & divisor[WIDTH-1];
  assign w_a_abs    = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_abs    = w_b_neg ? (~divisor + 1'b1) : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed && (dividend == MOST_NEG) && (divisor == '1);
  assign w_special  = w_div_zero | w_ovf;

  // The shifted partial remainder needs one extra bit; after the restoring
  // step it is always below the divisor, so WIDTH bits hold it.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_dvs;

  assign w_quo_fix = r_q_neg ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_r_neg ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_special ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == CNT_LAST) w_next = S_FIX;
      end
      S_FIX: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_next = w_special ? S_FIX : S_CALC;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      result  <= '0;
    end else if (w_accept) begin
      r_op  <= div_op;
      r_dvs <= w_b_abs;
      r_cnt <= '0;
      if (w_special) begin
        // Final values are loaded directly; cleared sign flags make FIX a
        // plain copy.
        r_quo   <= w_div_zero ? {WIDTH{1'b1}} : MOST_NEG;
        r_rem   <= w_div_zero ? dividend : '0;
        r_q_neg <= 1'b0;
        r_r_neg <= 1'b0;
      end else begin
        r_quo   <= w_a_abs;
        r_rem   <= '0;
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      r_rem <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
    end else if (r_state == S_FIX) begin
      result <= r_op[1] ? w_rem_fix : w_quo_fix;
    end
  end

  assign busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed vectors with literal expectations plus a
// boundary-weighted random run, checked against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  bit          prev_done = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .div_op   (div_op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      2'd1: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      2'd2: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h2;
      4: return 32'hFFFFFFFE;
      5: return 32'h80000000;
      6: return 32'h7FFFFFFF;
      7: return 32'($urandom_range(1000));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Result check on every done pulse, in issue order.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 0;
    end else begin
      if (done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done actual=%h required=no_done", result);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (result !== e) begin
            bad++;
            $display("FAIL result actual=%h required=%h", result, e);
          end
        end
        total++;
        if (prev_done) begin
          bad++;
          $display("FAIL done_width actual=2+ cycles required=1");
        end
      end
      prev_done = done;
    end
  end

  // One op from IDLE; checks latency (edges after accept) and busy cycle count.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res);
    int n;
    int bcnt;
    int exp_lat;
    bit seen;
    exp_lat = is_special(op, a, b) ? 1 : 33;
    @(negedge clk);
    div_op   = op;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(ref_div(op, a, b));
    @(posedge clk);
    #1;
    start    = 1'b0;
    div_op   = 2'($urandom_range(3));
    dividend = $urandom;
    divisor  = $urandom;
    seen = 0;
    bcnt = 0;
    n    = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
    res = result;
    chk("latency", 32'(n - 1), 32'(exp_lat));
    chk("busy_cycles", 32'(bcnt), 32'(exp_lat));
    chk("busy_at_done", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    div_op   = 2'd0;
    dividend = 32'h0;
    divisor  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Model pins.
    chk("model_div", ref_div(2'd0, 32'd20, 32'hFFFFFFFD), 32'hFFFFFFFA);
    chk("model_rem", ref_div(2'd2, 32'hFFFFFFEC, 32'd3), 32'hFFFFFFFE);
    chk("model_ovf", ref_div(2'd0, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    chk("model_remu", ref_div(2'd3, 32'hFFFFFFEC, 32'd3), 32'h2);

    run_op(2'd0, 32'd20, 32'hFFFFFFFD, r);        chk("div_20_m3", r, 32'hFFFFFFFA);
    run_op(2'd2, 32'hFFFFFFEC, 32'd3, r);         chk("rem_m20_3", r, 32'hFFFFFFFE);
    run_op(2'd3, 32'hFFFFFFEC, 32'd3, r);         chk("remu", r, 32'h2);
    run_op(2'd1, 32'd7, 32'd0, r);                chk("divu_by0", r, 32'hFFFFFFFF);
    run_op(2'd2, 32'd7, 32'd0, r);                chk("rem_by0", r, 32'h7);
    run_op(2'd0, 32'h80000000, 32'hFFFFFFFF, r);  chk("div_ovf", r, 32'h80000000);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, r);  chk("rem_ovf", r, 32'h0);
    run_op(2'd1, 32'h80000000, 32'hFFFFFFFF, r);  chk("divu_big", r, 32'h0);
    run_op(2'd0, 32'd0, 32'd5, r);                chk("div_zero_dividend", r, 32'h0);
    run_op(2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, r);  chk("rem_m7_m2", r, 32'hFFFFFFFF);

    // Stray start while busy is ignored; start held into DONE is taken at once.
    @(negedge clk);
    div_op = 2'd1; dividend = 32'hFFFFFFFF; divisor = 32'd2; start = 1'b1;
    exp_q.push_back(32'h7FFFFFFF);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    div_op = 2'd0; dividend = 32'd5; divisor = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    div_op = 2'd0; dividend = 32'd20; divisor = 32'hFFFFFFFD; start = 1'b1;
    exp_q.push_back(32'hFFFFFFFA);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_done_seen", {31'b0, done}, 32'h1);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(done && n > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", 32'(n - 1), 32'd33);

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    div_op = 2'd0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'd0, 32'd100, 32'd7, r);              chk("div_100_7", r, 32'd14);

    for (int i = 0; i < 1000; i++) begin
      run_op(2'($urandom_range(3)), pick(), pick(), r);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
